// File: rtl/ota_load_ctrl.sv
// Over-the-air image loader: parses MAGIC/LEN/payload/CSUM frames from the SPI byte stream,
// writes payload words to program memory and holds the CPU in reset until an image verifies.
module ota_load_ctrl #(
   parameter int          ADDR_W    = 12,
   parameter int          MAX_WORDS = 4096,
   parameter logic [7:0]  MAGIC     = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs_active,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   words_written
);

   localparam int          WW    = ADDR_W + 1;
   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t          state, state_next;
   logic [7:0]      len_lo;
   logic [WW-1:0]   n_words;
   logic [1:0]      byte_cnt;
   logic [23:0]     word_buf;
   logic [7:0]      csum;

   logic [15:0]     len_full;
   logic            len_bad;
   logic            in_frame;
   logic            start;
   logic            abort;
   logic            last_word;
   logic            word_end;

   always_comb begin
      len_full   = {rx_byte, len_lo};
      len_bad    = (len_full == 16'd0) || ({1'b0, len_full} > MAX_N);
      in_frame   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                   (state == S_DATA)   || (state == S_CSUM);
      start      = rx_valid && cs_active && (rx_byte == MAGIC) &&
                   ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
      abort      = in_frame && !cs_active;
      last_word  = (words_written + WW'(1)) == n_words;
      word_end   = rx_valid && (byte_cnt == 2'd3);

      state_next = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN_LO;
         S_LEN_LO:              if (rx_valid) state_next = S_LEN_HI;
         S_LEN_HI:              if (rx_valid) state_next = len_bad ? S_ERR : S_DATA;
         S_DATA:                if (word_end && last_word) state_next = S_CSUM;
         S_CSUM:                if (rx_valid) state_next = (rx_byte == csum) ? S_DONE : S_ERR;
         default:               state_next = S_IDLE;
      endcase
      // Chip-select loss terminates the frame regardless of any byte in flight.
      if (abort) state_next = S_ERR;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         cpu_rst_hold  <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_code      <= 2'd0;
         words_written <= '0;
         byte_cnt      <= 2'd0;
         csum          <= 8'd0;
      end else begin
         mem_we <= 1'b0;
         if (start) begin
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'd0;
            words_written <= '0;
            byte_cnt      <= 2'd0;
            csum          <= 8'd0;
            cpu_rst_hold  <= 1'b1;
         end else if (abort) begin
            error    <= 1'b1;
            err_code <= 2'd2;
         end else if (rx_valid) begin
            case (state)
               S_LEN_HI: begin
                  if (len_bad) begin
                     error    <= 1'b1;
                     err_code <= 2'd1;
                  end
               end
               S_DATA: begin
                  csum     <= csum + rx_byte;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     mem_we        <= 1'b1;
                     mem_addr      <= words_written[ADDR_W-1:0];
                     mem_wdata     <= {rx_byte, word_buf};
                     words_written <= words_written + WW'(1);
                  end
               end
               S_CSUM: begin
                  if (rx_byte == csum) begin
                     done         <= 1'b1;
                     cpu_rst_hold <= 1'b0;
                  end else begin
                     error    <= 1'b1;
                     err_code <= 2'd3;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Frame data registers carry no reset; every frame rewrites them before use.
   always_ff @(posedge clk) begin
      if (rx_valid && !abort) begin
         if (state == S_LEN_LO) len_lo <= rx_byte;
         if (state == S_LEN_HI && !len_bad) n_words <= len_full[WW-1:0];
         if (state == S_DATA && byte_cnt != 2'd3) word_buf[8*byte_cnt +: 8] <= rx_byte;
      end
   end

   assign busy = in_frame;

endmodule

// File: tb/tb_ota_load_ctrl.sv
// Directed bench for ota_load_ctrl: good/bad frames, length errors, abort, junk and mid-frame reset.
module tb_ota_load_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs_active;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_rst_hold;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  err_code;
   logic [12:0] words_written;

   int checks   = 0;
   int failures = 0;
   int nwe      = 0;
   int base;
   logic [11:0] we_addr [16];
   logic [31:0] we_data [16];

   ota_load_ctrl dut (
      .clk(clk), .rst(rst), .cs_active(cs_active), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_hold(cpu_rst_hold),
      .busy(busy), .done(done), .error(error), .err_code(err_code), .words_written(words_written)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         if (nwe < 16) begin
            we_addr[nwe] = mem_addr;
            we_data[nwe] = mem_wdata;
         end
         nwe = nwe + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sendb(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] ck);
      logic [7:0] f [11];
      f = '{8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
      for (int i = 0; i < 11; i++) sendb(f[i]);
      sendb(ck);
      idle(3);
   endtask

   initial begin
      rst = 1'b1; cs_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
      idle(3);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hold", 32'(cpu_rst_hold), 32'd0);
      chk("rst_flags", {29'd0, done, error, mem_we}, 32'd0);
      chk("rst_ww", 32'(words_written), 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);
      rst = 1'b0; cs_active = 1'b1;
      idle(2);

      // Test 1: good frame, first byte checked on its own.
      base = nwe;
      sendb(8'hA5);
      idle(1);
      chk("t1_hold_after_magic", 32'(cpu_rst_hold), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      sendb(8'h02); sendb(8'h00);
      sendb(8'h44); sendb(8'h33); sendb(8'h22); sendb(8'h11);
      sendb(8'hDD); sendb(8'hCC); sendb(8'hBB); sendb(8'hAA);
      sendb(8'hB8);
      idle(3);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_error", 32'(error), 32'd0);
      chk("t1_ww", 32'(words_written), 32'd2);
      chk("t1_hold", 32'(cpu_rst_hold), 32'd0);
      chk("t1_busy_end", 32'(busy), 32'd0);
      chk("t1_nwe", 32'(nwe - base), 32'd2);
      chk("t1_addr0", 32'(we_addr[base]), 32'd0);
      chk("t1_data0", we_data[base], 32'h11223344);
      chk("t1_addr1", 32'(we_addr[base+1]), 32'd1);
      chk("t1_data1", we_data[base+1], 32'hAABBCCDD);
      sendb(8'h00); idle(2);
      chk("t1_trailing_ignored", {30'd0, done, error}, 32'd2);

      // Test 2: bad checksum.
      base = nwe;
      send_frame(8'hB9);
      chk("t2_error", 32'(error), 32'd1);
      chk("t2_code", 32'(err_code), 32'd3);
      chk("t2_hold", 32'(cpu_rst_hold), 32'd1);
      chk("t2_done", 32'(done), 32'd0);
      chk("t2_nwe", 32'(nwe - base), 32'd2);

      // Test 3: zero length and oversize length.
      base = nwe;
      sendb(8'hA5); sendb(8'h00); sendb(8'h00); idle(2);
      chk("t3_zero_err", {30'd0, error, busy}, 32'd2);
      chk("t3_zero_code", 32'(err_code), 32'd1);
      chk("t3_zero_nwe", 32'(nwe - base), 32'd0);
      sendb(8'hA5); sendb(8'h01); sendb(8'h10); idle(2);
      chk("t3_big_code", 32'(err_code), 32'd1);
      chk("t3_big_hold", 32'(cpu_rst_hold), 32'd1);

      // Test 4: chip-select dropped after the fifth payload byte.
      base = nwe;
      sendb(8'hA5); sendb(8'h02); sendb(8'h00);
      sendb(8'h44); sendb(8'h33); sendb(8'h22); sendb(8'h11); sendb(8'hDD);
      @(negedge clk);
      rx_byte = 8'hCC;
      cs_active = 1'b0;
      idle(3);
      chk("t4_code", 32'(err_code), 32'd2);
      chk("t4_error", 32'(error), 32'd1);
      chk("t4_nwe", 32'(nwe - base), 32'd1);
      chk("t4_ww", 32'(words_written), 32'd1);
      chk("t4_hold", 32'(cpu_rst_hold), 32'd1);
      cs_active = 1'b1;
      idle(1);

      // Test 5: junk bytes back to back with the frame.
      base = nwe;
      sendb(8'h00); sendb(8'hFF); sendb(8'h5A);
      send_frame(8'hB8);
      chk("t5_done", {29'd0, done, error, cpu_rst_hold}, 32'd4);
      chk("t5_code", 32'(err_code), 32'd0);
      chk("t5_ww", 32'(words_written), 32'd2);
      chk("t5_nwe", 32'(nwe - base), 32'd2);
      chk("t5_data1", we_data[base+1], 32'hAABBCCDD);

      // Test 6: reset during DATA, then a fresh good frame.
      sendb(8'hA5); sendb(8'h02); sendb(8'h00); sendb(8'h44); sendb(8'h33);
      @(negedge clk);
      rx_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_hold", 32'(cpu_rst_hold), 32'd0);
      chk("t6_we", 32'(mem_we), 32'd0);
      chk("t6_ww", 32'(words_written), 32'd0);
      idle(1);
      base = nwe;
      send_frame(8'hB8);
      chk("t6_done", {29'd0, done, error, cpu_rst_hold}, 32'd4);
      chk("t6_data0", we_data[base], 32'h11223344);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
